// File: rtl/axi_bus_pkg.sv
// Shared AXI4 constants for the SweRVolf memory-path bus: default widths,
// response codes and burst encodings.
package axi_bus_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 6;
  localparam int AXI_USER_WIDTH = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;
endpackage

// File: rtl/axi_bus_sync_slice_if.sv
// AXI4 bus bundle (five channels); master drives AW/W/AR and the B/R readies.
interface axi_bus_sync_slice_if
  import axi_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int USER_WIDTH = AXI_USER_WIDTH
) ();
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_region;
  logic [3:0]              aw_qos;
  logic [5:0]              aw_atop;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid, aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid, w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid, b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_region;
  logic [3:0]              ar_qos;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid, ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid, r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_atop, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_skid_slice.sv
// Two-entry valid/ready register slice: an output register plus one skid
// register, so ready can be a flop without losing full throughput.
module axi_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             skid_vld;
  logic [WIDTH-1:0] skid_data;
  logic             push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b0;
    end else if (!out_valid || pop) begin
      // Output register frees up: refill from skid first to keep FIFO order.
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_vld  <= push;
        if (push) skid_data <= in_data;
        in_ready  <= !push;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
        in_ready  <= 1'b1;
      end
    end else if (push) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= !skid_vld;
    end
  end
endmodule

// File: rtl/axi_bus_sync_slice.sv
// Full-bandwidth AXI4 register slice: every channel passes through its own
// two-entry skid slice, so no input reaches an output combinationally.
module axi_bus_sync_slice
  import axi_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int USER_WIDTH = AXI_USER_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  axi_bus_sync_slice_if.slave  s,
  axi_bus_sync_slice_if.master m
);
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + 6 + USER_WIDTH;
  localparam int AR_W = AW_W - 6;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

  logic [AW_W-1:0] aw_q;
  logic [W_W-1:0]  w_q;
  logic [AR_W-1:0] ar_q;
  logic [B_W-1:0]  b_q;
  logic [R_W-1:0]  r_q;

  axi_skid_slice #(.WIDTH(AW_W)) u_aw (
    .clk, .rst,
    .in_valid (s.aw_valid), .in_ready (s.aw_ready),
    .in_data  ({s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                s.aw_cache, s.aw_prot, s.aw_region, s.aw_qos, s.aw_atop, s.aw_user}),
    .out_valid(m.aw_valid), .out_ready(m.aw_ready), .out_data(aw_q)
  );
  assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
          m.aw_cache, m.aw_prot, m.aw_region, m.aw_qos, m.aw_atop, m.aw_user} = aw_q;

  axi_skid_slice #(.WIDTH(W_W)) u_w (
    .clk, .rst,
    .in_valid (s.w_valid), .in_ready (s.w_ready),
    .in_data  ({s.w_data, s.w_strb, s.w_last, s.w_user}),
    .out_valid(m.w_valid), .out_ready(m.w_ready), .out_data(w_q)
  );
  assign {m.w_data, m.w_strb, m.w_last, m.w_user} = w_q;

  axi_skid_slice #(.WIDTH(AR_W)) u_ar (
    .clk, .rst,
    .in_valid (s.ar_valid), .in_ready (s.ar_ready),
    .in_data  ({s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                s.ar_cache, s.ar_prot, s.ar_region, s.ar_qos, s.ar_user}),
    .out_valid(m.ar_valid), .out_ready(m.ar_ready), .out_data(ar_q)
  );
  assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
          m.ar_cache, m.ar_prot, m.ar_region, m.ar_qos, m.ar_user} = ar_q;

  // Return channels run memory side to CPU side.
  axi_skid_slice #(.WIDTH(B_W)) u_b (
    .clk, .rst,
    .in_valid (m.b_valid), .in_ready (m.b_ready),
    .in_data  ({m.b_id, m.b_resp, m.b_user}),
    .out_valid(s.b_valid), .out_ready(s.b_ready), .out_data(b_q)
  );
  assign {s.b_id, s.b_resp, s.b_user} = b_q;

  axi_skid_slice #(.WIDTH(R_W)) u_r (
    .clk, .rst,
    .in_valid (m.r_valid), .in_ready (m.r_ready),
    .in_data  ({m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user}),
    .out_valid(s.r_valid), .out_ready(s.r_ready), .out_data(r_q)
  );
  assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user} = r_q;
endmodule

// File: tb/tb_axi_bus_sync_slice.sv
// Directed and randomized checks of the AXI register slice; channels are
// handled generically as flat payloads: 0=AW 1=W 2=AR 3=B 4=R.
module tb_axi_bus_sync_slice;
  import axi_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_bus_sync_slice_if sif ();
  axi_bus_sync_slice_if mif ();

  axi_bus_sync_slice dut (.clk(clk), .rst(rst), .s(sif), .m(mif));

  logic        src_v [5];
  logic [79:0] src_d [5];
  logic        src_r [5];
  logic        dst_v [5];
  logic [79:0] dst_d [5];
  logic        dst_r [5];

  int nasserts = 0;
  int nfail    = 0;

  // Forward sources / sinks
  assign sif.aw_valid = src_v[0];
  assign {sif.aw_id, sif.aw_addr, sif.aw_len, sif.aw_size, sif.aw_burst, sif.aw_lock,
          sif.aw_cache, sif.aw_prot, sif.aw_region, sif.aw_qos, sif.aw_atop, sif.aw_user} = src_d[0][73:0];
  assign src_r[0] = sif.aw_ready;
  assign dst_v[0] = mif.aw_valid;
  assign dst_d[0] = {6'b0, mif.aw_id, mif.aw_addr, mif.aw_len, mif.aw_size, mif.aw_burst, mif.aw_lock,
                     mif.aw_cache, mif.aw_prot, mif.aw_region, mif.aw_qos, mif.aw_atop, mif.aw_user};
  assign mif.aw_ready = dst_r[0];

  assign sif.w_valid = src_v[1];
  assign {sif.w_data, sif.w_strb, sif.w_last, sif.w_user} = src_d[1][73:0];
  assign src_r[1] = sif.w_ready;
  assign dst_v[1] = mif.w_valid;
  assign dst_d[1] = {6'b0, mif.w_data, mif.w_strb, mif.w_last, mif.w_user};
  assign mif.w_ready = dst_r[1];

  assign sif.ar_valid = src_v[2];
  assign {sif.ar_id, sif.ar_addr, sif.ar_len, sif.ar_size, sif.ar_burst, sif.ar_lock,
          sif.ar_cache, sif.ar_prot, sif.ar_region, sif.ar_qos, sif.ar_user} = src_d[2][67:0];
  assign src_r[2] = sif.ar_ready;
  assign dst_v[2] = mif.ar_valid;
  assign dst_d[2] = {12'b0, mif.ar_id, mif.ar_addr, mif.ar_len, mif.ar_size, mif.ar_burst, mif.ar_lock,
                     mif.ar_cache, mif.ar_prot, mif.ar_region, mif.ar_qos, mif.ar_user};
  assign mif.ar_ready = dst_r[2];

  // Return sources / sinks
  assign mif.b_valid = src_v[3];
  assign {mif.b_id, mif.b_resp, mif.b_user} = src_d[3][8:0];
  assign src_r[3] = mif.b_ready;
  assign dst_v[3] = sif.b_valid;
  assign dst_d[3] = {71'b0, sif.b_id, sif.b_resp, sif.b_user};
  assign sif.b_ready = dst_r[3];

  assign mif.r_valid = src_v[4];
  assign {mif.r_id, mif.r_data, mif.r_resp, mif.r_last, mif.r_user} = src_d[4][73:0];
  assign src_r[4] = mif.r_ready;
  assign dst_v[4] = sif.r_valid;
  assign dst_d[4] = {6'b0, sif.r_id, sif.r_data, sif.r_resp, sif.r_last, sif.r_user};
  assign sif.r_ready = dst_r[4];

  function automatic logic [79:0] chmask(input int ch);
    int w;
    case (ch)
      2:       w = 68;
      3:       w = 9;
      default: w = 74;
    endcase
    return (80'd1 << w) - 80'd1;
  endfunction

  function automatic logic [79:0] wbeat(input int k);
    logic [63:0] d;
    d = 64'hCAFE_0000_0000_0000 + 64'(k);
    return {6'b0, d, 8'hF0 | 8'(k), k == 3, 1'b1};
  endfunction

  function automatic logic [79:0] rbeat(input int k);
    return {6'b0, 6'h2A, 64'(k), 2'b00, k == 15, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int ch = 0; ch < 5; ch++) begin
      src_v[ch] = 1'b0; src_d[ch] = '0; dst_r[ch] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #4;
    for (int ch = 0; ch < 5; ch++) begin
      nasserts++;
      if (src_r[ch] !== 1'b0 || dst_v[ch] !== 1'b0 || dst_d[ch] !== 80'd0) begin
        nfail++;
        $display("FAIL reset_hold ch%0d: ready=%b valid=%b data=%h, want 0/0/0", ch, src_r[ch], dst_v[ch], dst_d[ch]);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #4;
    for (int ch = 0; ch < 5; ch++) begin
      nasserts++;
      if (src_r[ch] !== 1'b1 || dst_v[ch] !== 1'b0 || dst_d[ch] !== 80'd0) begin
        nfail++;
        $display("FAIL reset_release ch%0d: ready=%b valid=%b data=%h, want 1/0/0", ch, src_r[ch], dst_v[ch], dst_d[ch]);
      end
    end
  endtask

  task automatic test_single_write();
    logic [79:0] aw_exp, w_exp, b_exp;
    aw_exp = {6'b0, 6'h05, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR, 1'b0, 4'h3, 3'b010, 4'h0, 4'h0, 6'h21, 1'b1};
    w_exp  = {6'b0, 64'hDEADBEEF_01234567, 8'hFF, 1'b1, 1'b0};
    b_exp  = {71'b0, 6'h05, RESP_OKAY, 1'b0};
    for (int ch = 0; ch < 5; ch++) dst_r[ch] = 1'b1;
    @(negedge clk);
    src_v[0] = 1'b1; src_d[0] = aw_exp;
    src_v[1] = 1'b1; src_d[1] = w_exp;
    @(negedge clk);
    src_v[0] = 1'b0; src_v[1] = 1'b0;
    #4;
    nasserts++;
    if (dst_v[0] !== 1'b1 || dst_d[0] !== aw_exp) begin
      nfail++; $display("FAIL write_aw: valid=%b data=%h, want 1 %h", dst_v[0], dst_d[0], aw_exp);
    end
    nasserts++;
    if (dst_v[1] !== 1'b1 || dst_d[1] !== w_exp) begin
      nfail++; $display("FAIL write_w: valid=%b data=%h, want 1 %h", dst_v[1], dst_d[1], w_exp);
    end
    @(negedge clk);
    src_v[3] = 1'b1; src_d[3] = b_exp;
    #4;
    nasserts++;
    if (dst_v[0] !== 1'b0 || dst_v[1] !== 1'b0) begin
      nfail++; $display("FAIL write_drain: aw_valid=%b w_valid=%b, want 0 0", dst_v[0], dst_v[1]);
    end
    @(negedge clk);
    src_v[3] = 1'b0;
    #4;
    nasserts++;
    if (dst_v[3] !== 1'b1 || dst_d[3] !== b_exp) begin
      nfail++; $display("FAIL write_b: valid=%b data=%h, want 1 %h", dst_v[3], dst_d[3], b_exp);
    end
  endtask

  task automatic test_stream_read();
    dst_r[4] = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      src_v[4] = (i < 16);
      src_d[4] = (i < 16) ? rbeat(i) : '0;
      #4;
      if (i < 16) begin
        nasserts++;
        if (src_r[4] !== 1'b1) begin
          nfail++; $display("FAIL stream_ready beat%0d: ready=%b, want 1", i, src_r[4]);
        end
      end
      if (i >= 1) begin
        nasserts++;
        if (dst_v[4] !== 1'b1 || dst_d[4] !== rbeat(i - 1)) begin
          nfail++; $display("FAIL stream_beat%0d: valid=%b data=%h, want 1 %h", i - 1, dst_v[4], dst_d[4], rbeat(i - 1));
        end
      end
    end
    @(negedge clk); #4;
    nasserts++;
    if (dst_v[4] !== 1'b0) begin
      nfail++; $display("FAIL stream_end: valid=%b, want 0", dst_v[4]);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int got = 0;
    dst_r[1] = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (c == 6) dst_r[1] = 1'b1;
      src_v[1] = (k < 4);
      src_d[1] = wbeat(k);
      #4;
      if (c >= 3 && c < 6) begin
        nasserts++;
        if (src_r[1] !== 1'b0 || dst_v[1] !== 1'b1 || dst_d[1] !== wbeat(0)) begin
          nfail++;
          $display("FAIL bp_hold c%0d: ready=%b valid=%b data=%h, want 0 1 %h", c, src_r[1], dst_v[1], dst_d[1], wbeat(0));
        end
      end
      if (src_v[1] && src_r[1]) k++;
      if (dst_v[1] && dst_r[1]) begin
        nasserts++;
        if (dst_d[1] !== wbeat(got)) begin
          nfail++; $display("FAIL bp_order beat%0d: data=%h, want %h", got, dst_d[1], wbeat(got));
        end
        got++;
      end
    end
    nasserts++;
    if (got != 4) begin
      nfail++; $display("FAIL bp_count: got %0d beats, want 4", got);
    end
    @(negedge clk);
    src_v[1] = 1'b0;
    #4;
    nasserts++;
    if (dst_v[1] !== 1'b0) begin
      nfail++; $display("FAIL bp_dup: valid=%b after drain, want 0", dst_v[1]);
    end
  endtask

  task automatic test_mid_reset();
    dst_r[2] = 1'b0;
    @(negedge clk);
    src_v[2] = 1'b1; src_d[2] = 80'h0_1111_2222_3333_4444_5 & chmask(2);
    @(negedge clk);
    src_d[2] = 80'h0_AAAA_BBBB_CCCC_DDDD_E & chmask(2);
    @(negedge clk);
    src_v[2] = 1'b0;
    #4;
    nasserts++;
    if (src_r[2] !== 1'b0 || dst_v[2] !== 1'b1) begin
      nfail++; $display("FAIL midrst_full: ready=%b valid=%b, want 0 1", src_r[2], dst_v[2]);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #4;
    nasserts++;
    if (src_r[2] !== 1'b0 || dst_v[2] !== 1'b0 || dst_d[2] !== 80'd0) begin
      nfail++; $display("FAIL midrst_clear: ready=%b valid=%b data=%h, want 0 0 0", src_r[2], dst_v[2], dst_d[2]);
    end
    rst = 1'b0;
    dst_r[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #4;
      nasserts++;
      if (dst_v[2] !== 1'b0) begin
        nfail++; $display("FAIL midrst_stale c%0d: valid=%b data=%h, want 0", i, dst_v[2], dst_d[2]);
      end
    end
    nasserts++;
    if (src_r[2] !== 1'b1) begin
      nfail++; $display("FAIL midrst_ready: ready=%b, want 1", src_r[2]);
    end
  endtask

  task automatic test_random();
    logic [79:0] sb [5][$];
    logic        fired_in [5];
    logic        hold     [5];
    logic [79:0] hold_d   [5];
    logic [79:0] exp;
    for (int ch = 0; ch < 5; ch++) begin
      fired_in[ch] = 1'b0; hold[ch] = 1'b0; hold_d[ch] = '0; src_v[ch] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int ch = 0; ch < 5; ch++) begin
        if (!src_v[ch] || fired_in[ch]) begin
          src_v[ch] = (cyc < 9980) && ($urandom_range(0, 3) != 0);
          src_d[ch] = 80'({$urandom(), $urandom(), $urandom()}) & chmask(ch);
        end
        dst_r[ch] = (cyc >= 9980) || ($urandom_range(0, 2) != 0);
      end
      #4;
      for (int ch = 0; ch < 5; ch++) begin
        if (hold[ch]) begin
          nasserts++;
          if (dst_v[ch] !== 1'b1 || dst_d[ch] !== hold_d[ch]) begin
            nfail++;
            $display("FAIL rnd_stable ch%0d cyc%0d: valid=%b data=%h, want 1 %h", ch, cyc, dst_v[ch], dst_d[ch], hold_d[ch]);
          end
        end
        fired_in[ch] = src_v[ch] && src_r[ch];
        if (fired_in[ch]) sb[ch].push_back(src_d[ch]);
        if (dst_v[ch] && dst_r[ch]) begin
          nasserts++;
          if (sb[ch].size() == 0) begin
            nfail++; $display("FAIL rnd_extra ch%0d cyc%0d: data=%h, want no beat", ch, cyc, dst_d[ch]);
          end else begin
            exp = sb[ch].pop_front();
            if (dst_d[ch] !== exp) begin
              nfail++; $display("FAIL rnd_order ch%0d cyc%0d: data=%h, want %h", ch, cyc, dst_d[ch], exp);
            end
          end
        end
        hold[ch]   = dst_v[ch] && !dst_r[ch];
        hold_d[ch] = dst_d[ch];
      end
    end
    for (int ch = 0; ch < 5; ch++) begin
      nasserts++;
      if (sb[ch].size() != 0) begin
        nfail++; $display("FAIL rnd_lost ch%0d: %0d beats undelivered, want 0", ch, sb[ch].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stream_read();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end
endmodule

// File: doc/axi_bus_sync_slice.md
Name: axi_bus_sync_slice

Overview:
- Single-clock, full-bandwidth AXI4 register slice between a manager port (s_*, CPU side) and a subordinate port (m_*, memory side).
- Registers all five channels (AW, W, B, AR, R) to break timing paths in the SweRVolf memory path.
- Channel parameters match the system AXI_BUS: 32-bit address, 64-bit data, 6-bit ID, 1-bit user.
- Transparent to protocol: no reordering, no ID or burst interpretation, no response generation.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR.
- DATA_WIDTH, 64, data width of W/R; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 6, ID width of AW/AR/B/R.
- USER_WIDTH, 1, user sideband width on all channels.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- s_aw_{id,addr,len[8],size[3],burst[2],lock[1],cache[4],prot[3],region[4],qos[4],atop[6],user}  in  per field  write address payload.
- s_aw_valid in 1, s_aw_ready out 1  write address handshake.
- s_w_{data,strb,last,user}  in  per field  write data payload.
- s_w_valid in 1, s_w_ready out 1  write data handshake.
- s_b_{id,resp[2],user}  out  per field  write response payload.
- s_b_valid out 1, s_b_ready in 1  write response handshake.
- s_ar_{same fields as AW without atop}  in  per field  read address payload.
- s_ar_valid in 1, s_ar_ready out 1  read address handshake.
- s_r_{id,data,resp[2],last,user}  out  per field  read data payload.
- s_r_valid out 1, s_r_ready in 1  read data handshake.
- m_aw_*/m_w_*/m_ar_*  out (ready in): mirror of the s_ forward channels.
- m_b_*/m_r_*  in (ready out): mirror of the s_ return channels.

Behaviour:
- Each channel has an independent two-entry skid slice. Forward channels (AW, W, AR) flow s to m; return channels (B, R) flow m to s.
- Transfer occurs on a rising clk edge where valid and ready are both 1.
- All outputs, valid and ready included, come straight from flops. There is no combinational path from any input to any output.
- Latency: a beat accepted at edge N is presented on the far side at edge N+1. Sustained throughput is one beat per cycle per channel.
- Ready rule: ready=1 while fewer than 2 entries are held. It drops the cycle after the second entry fills and returns the cycle after an entry drains.
- Output stability: output valid and payload hold stable while valid=1 and ready=0.
- Simultaneous push and pop on a one-entry slice: occupancy stays 1, the new beat is presented next cycle, and no bubble is inserted.
- Pop-only empties the slice; valid drops the next cycle.
- Ordering is strictly FIFO per channel. There is no cross-channel coupling, so W may precede AW exactly as the source issued it.
- Payload is carried bit-exact, including last, atop, strb and user.
- Reset (rst=1 at a clk edge):
  - all valid outputs = 0 and all ready outputs = 0 while rst=1;
  - all payload registers = 0 and occupancy = 0;
  - ready rises to 1 on the first edge after rst deasserts.
- Reset mid-burst: in-flight beats are discarded with no flush or completion, and the slice is empty after reset.

Decomposition:
- Shared package axi_bus_pkg:
  - default width constants;
  - AXI resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - burst codes FIXED/INCR/WRAP.
- One sub-module, axi_skid_slice (parameter WIDTH): generic two-entry valid/ready register slice.
  - Instantiated five times, once per channel.
  - Each instance carries that channel's fields concatenated into one WIDTH-bit payload.

Test Plan:
- Reset release: rst high 3 cycles then low → all valids 0 during reset; s_aw/s_w/s_ar/m_b/m_r ready=1 one cycle after release; payload outputs 0.
- Single write: AW id=6'h05 addr=32'h8000_0000 len=0 size=3, W data=64'hDEADBEEF_01234567 strb=8'hFF last=1 → identical values on m_aw/m_w one cycle later; m_b id=5 resp=OKAY appears on s_b one cycle later.
- Streaming read: R burst of 16 beats, data=beat index, m_r_valid and s_r_ready held 1 → 16 beats on s_r on consecutive cycles starting 1 cycle after the first, last only on beat 15, no bubbles.
- Backpressure: m_w_ready=0 while s_w sends 4 beats → slice accepts 2, s_w_ready drops; m_w holds beat 0 stable; after m_w_ready=1 all 4 beats emerge in order, none lost or duplicated.
- Randomized valid/ready on all five channels for 10k cycles → scoreboard shows bit-exact FIFO order per channel (atop, user and strb included), never valid drop without handshake.
- Mid-burst reset: rst asserted with 2 entries held in AR → next cycle m_ar_valid=0 and s_ar_ready=0; after release no stale beat appears.
